// File: rtl/bank_conflict_resolver_n.sv
// Splits an edge bundle into conflict-free passes: each pass issues the lowest
// pending lanes whose source/destination bank fields do not collide.
module bank_conflict_resolver_n #(
  parameter int unsigned EDGE_W  = 96,
  parameter int unsigned LANES   = 8,
  parameter int unsigned BANK_W  = 5,
  parameter int unsigned SRC_LSB = 0,
  parameter int unsigned DST_LSB = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [EDGE_W*LANES-1:0]   in_data,
  input  logic [LANES-1:0]          in_mask,
  output logic                      in_ready,
  input  logic [1:0]                mode,
  input  logic                      out_ready,
  output logic [EDGE_W*LANES-1:0]   out_data,
  output logic [LANES-1:0]          out_valid,
  output logic [31:0]               bundle_cnt,
  output logic [31:0]               stall_cnt
);

  localparam int unsigned DATA_W = EDGE_W * LANES;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] MODE_BOTH   = 2'b00;
  localparam logic [1:0] MODE_SRC    = 2'b01;
  localparam logic [1:0] MODE_DST    = 2'b10;

  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic [LANES-1:0]  out_valid_q,  out_valid_d;
  logic [LANES-1:0]  issued_q,     issued_d;
  logic [CNT_W-1:0]  bundle_cnt_q, bundle_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic [BANK_W-1:0] src_f [LANES];
  logic [BANK_W-1:0] dst_f [LANES];
  logic [LANES-1:0]  pending;
  logic [LANES-1:0]  grant;
  logic              advance;
  logic              drain;
  logic              blocked;

  function automatic logic lanes_conflict(input logic [1:0] m,
                                          input logic [BANK_W-1:0] si,
                                          input logic [BANK_W-1:0] sj,
                                          input logic [BANK_W-1:0] di,
                                          input logic [BANK_W-1:0] dj);
    logic c;
    c = 1'b0;
    case (m)
      MODE_BOTH: c = (si == sj) || (di == dj);
      MODE_SRC:  c = (si == sj);
      MODE_DST:  c = (di == dj);
      default:   c = 1'b0;
    endcase
    return c;
  endfunction

  // Bank fields of every lane.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      src_f[i] = in_data[EDGE_W*i + SRC_LSB +: BANK_W];
      dst_f[i] = in_data[EDGE_W*i + DST_LSB +: BANK_W];
    end
  end

  assign pending = in_mask & ~issued_q;
  assign drain   = (out_valid_q == '0) || out_ready;
  assign advance = in_valid && drain;

  // Priority grant: a lane yields to any lower lane already granted this pass.
  always_comb begin
    grant   = '0;
    blocked = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      blocked = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (grant[j] && lanes_conflict(mode, src_f[i], src_f[j], dst_f[i], dst_f[j]))
          blocked = 1'b1;
      end
      if (advance && pending[i] && !blocked)
        grant[i] = 1'b1;
    end
  end

  assign in_ready = !rst && advance && ((pending & ~grant) == '0);

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    issued_d     = issued_q;
    bundle_cnt_d = bundle_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    if (advance) begin
      out_valid_d = grant;
      out_data_d  = in_data;
    end else if (drain) begin
      out_valid_d = '0;
    end

    if (in_ready)
      issued_d = '0;
    else if (advance)
      issued_d = issued_q | grant;

    if (in_ready && (bundle_cnt_q != '1))
      bundle_cnt_d = bundle_cnt_q + CNT_W'(1);
    if (advance && !in_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= '0;
      issued_q     <= '0;
      bundle_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      issued_q     <= issued_d;
      bundle_cnt_q <= bundle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign bundle_cnt = bundle_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_bank_conflict_resolver_n.sv
// Scoreboard bench for bank_conflict_resolver_n: stimulus pushes expected
// passes, a forked monitor pops and compares whenever an output is accepted.
module tb_bank_conflict_resolver_n;

  localparam int unsigned EDGE_W = 96;
  localparam int unsigned LANES  = 8;
  localparam int unsigned DW     = EDGE_W * LANES;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [7:0]    in_mask;
  logic          in_ready;
  logic [1:0]    mode;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_valid;
  logic [31:0]   bundle_cnt;
  logic [31:0]   stall_cnt;

  typedef struct {
    logic [7:0]    v;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  logic [4:0] src_a [8];
  logic [4:0] dst_a [8];

  bank_conflict_resolver_n #(
    .EDGE_W(EDGE_W), .LANES(LANES), .BANK_W(5), .SRC_LSB(0), .DST_LSB(32)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_mask(in_mask), .in_ready(in_ready), .mode(mode),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .bundle_cnt(bundle_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane word: tag in [95:64], dst bank at 32, src bank at 0.
  function automatic logic [DW-1:0] build(input logic [7:0] tag);
    logic [DW-1:0] d;
    logic [95:0]   w;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      w = '0;
      w[4:0]   = src_a[i];
      w[36:32] = dst_a[i];
      w[95:64] = {16'hA5C3, tag, 8'(i)};
      d[96*i +: 96] = w;
    end
    return d;
  endfunction

  task automatic cyc(input logic [7:0] g, input logic r);
    exp_t e;
    @(negedge clk);
    chk("in_ready", DW'(in_ready), DW'(r));
    if (g != 8'h00) begin
      e.v = g;
      e.d = in_data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic set_serial(input logic [7:0] tag);
    for (int i = 0; i < 8; i++) begin
      src_a[i] = 5'd3;
      dst_a[i] = 5'(8 + i);
    end
    in_data  = build(tag);
    in_mask  = 8'hFF;
    mode     = 2'b01;
    in_valid = 1'b1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; mode = 2'b00; out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid != 8'h00 && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_out: got out_valid %0h with empty scoreboard", out_valid);
          end else begin
            e = exp_q.pop_front();
            chk("out_valid", DW'(out_valid), DW'(e.v));
            chk("out_data", out_data, e.d);
          end
        end
      end
    join_none

    // Reset state.
    #2;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_bundle_cnt", DW'(bundle_cnt), '0);
    chk("rst_stall_cnt", DW'(stall_cnt), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Conflict-free bundle in one pass.
    for (int i = 0; i < 8; i++) begin
      src_a[i] = 5'(i);
      dst_a[i] = 5'(8 + i);
    end
    in_data = build(8'h01); in_mask = 8'hFF; mode = 2'b00; in_valid = 1'b1;
    cyc(8'hFF, 1'b1);
    chk("cf_bundle_cnt", DW'(bundle_cnt), DW'(32'd1));
    chk("cf_stall_cnt", DW'(stall_cnt), '0);
    idle();

    // Full serialisation on shared source bank.
    set_serial(8'h02);
    for (int k = 0; k < 8; k++) cyc(8'(1 << k), k == 7);
    chk("ser_stall_cnt", DW'(stall_cnt), DW'(32'd7));
    chk("ser_bundle_cnt", DW'(bundle_cnt), DW'(32'd2));
    idle();

    // Mode selection: lanes 0,1 share dst only.
    for (int i = 0; i < 8; i++) begin
      src_a[i] = 5'(i + 1);
      dst_a[i] = 5'(i == 1 ? 20 : 20 + i);
    end
    in_data = build(8'h03); in_mask = 8'h03; mode = 2'b01; in_valid = 1'b1;
    cyc(8'h03, 1'b1);
    idle();
    in_data = build(8'h04); mode = 2'b10; in_valid = 1'b1;
    cyc(8'h01, 1'b0);
    cyc(8'h02, 1'b1);
    idle();
    set_serial(8'h05); mode = 2'b11;
    cyc(8'hFF, 1'b1);
    chk("mode_stall_cnt", DW'(stall_cnt), DW'(32'd8));
    chk("mode_bundle_cnt", DW'(bundle_cnt), DW'(32'd5));
    idle();

    // Backpressure after the first serial pass.
    set_serial(8'h06);
    cyc(8'h01, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", DW'(in_ready), '0);
      chk("bp_out_valid", DW'(out_valid), DW'(8'h01));
      chk("bp_stall_cnt", DW'(stall_cnt), DW'(32'd9));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 1; k < 8; k++) cyc(8'(1 << k), k == 7);
    chk("bp_stall_end", DW'(stall_cnt), DW'(32'd15));
    chk("bp_bundle_cnt", DW'(bundle_cnt), DW'(32'd6));
    idle();

    // Masking: only lanes 0 and 2 present and they share a source bank.
    for (int i = 0; i < 8; i++) begin
      src_a[i] = 5'(i == 2 ? 0 : i);
      dst_a[i] = 5'(16 + i);
    end
    in_data = build(8'h07); in_mask = 8'h05; mode = 2'b01; in_valid = 1'b1;
    cyc(8'h01, 1'b0);
    cyc(8'h04, 1'b1);
    in_mask = 8'h00;
    cyc(8'h00, 1'b1);
    chk("empty_out_valid", DW'(out_valid), '0);
    chk("mask_bundle_cnt", DW'(bundle_cnt), DW'(32'd8));
    chk("mask_stall_cnt", DW'(stall_cnt), DW'(32'd16));
    idle();

    // Reset in the middle of a serial bundle.
    set_serial(8'h08);
    for (int k = 0; k < 3; k++) cyc(8'(1 << k), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", DW'(out_valid), '0);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_bundle", DW'(bundle_cnt), '0);
    chk("mid_rst_stall", DW'(stall_cnt), '0);
    chk("mid_rst_in_ready", DW'(in_ready), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) cyc(8'(1 << k), k == 7);
    chk("post_rst_stall", DW'(stall_cnt), DW'(32'd7));
    chk("post_rst_bundle", DW'(bundle_cnt), DW'(32'd1));
    idle();
    idle();

    chk("scoreboard_empty", DW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
